mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative RISC-V M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU + W forms).
//  Sits in EX beside the single-cycle ALU; the pipeline stalls on in_ready/out_valid.
//  Parametrised in XLEN. Uses the same WordOp semantics as the ALU: a word op computes on bits [31:0]
//  and sign-extends the 32-bit result to XLEN. Multi-cycle, with valid/ready handshakes and a flush.
// PARAMETERS
//  XLEN   64  datapath width (32 or 64; WordOp ignored when 32)
//  TAG_W  5   width of opaque tag (rd index) carried with each op
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      op request
//  in_ready   out  1      unit can accept; high only in IDLE and rst_n=1
//  funct3     in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  word_op    in   1      1 = W-form (MULW/DIVW/DIVUW/REMW/REMUW)
//  operand1   in   XLEN   rs1
//  operand2   in   XLEN   rs2
//  tag_in     in   TAG_W  tag captured on accept
//  flush      in   1      kill the in-flight op (branch mispredict/trap)
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer takes result
//  out_result out  XLEN   result
//  out_tag    out  TAG_W  tag of the result
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, out_valid=0, out_result=0, out_tag=0, all internal regs 0.
//  - Accept: in_valid & in_ready & !flush at edge; operands, funct3, word_op and tag are latched.
//  - States: IDLE -> (accept) CALC | DONE(special case); CALC -(count==N-1)-> FIX -> DONE;
//    DONE -(out_ready)-> IDLE.  N = 32 if word_op && XLEN==64, else XLEN.
//  - Word op: operands are truncated to [31:0] and sign- or zero-extended per signedness; the 32-bit result is sign-extended.
//    word_op with funct3 001/010/011 is treated as MULW (the decoder never issues it).
//  - Signed ops: magnitudes are taken on accept; the sign is applied in FIX. MULHSU: rs1 signed, rs2 unsigned.
//  - MUL: shift-add, 1 bit/cycle, 2N-bit product; MUL(W) returns the low N bits and MULH* the high N bits.
//  - DIV: restoring, 1 quotient bit/cycle; REM sign follows the dividend; DIV truncates toward zero.
//  - Latency: out_valid rises exactly N+2 cycles after the accept edge (N CALC + FIX + DONE entry).
//  - Special cases are resolved at accept and go straight to DONE, so out_valid is high the next cycle:
//    divide by zero: DIV* quotient = all ones, REM* = dividend (word-extended for W).
//    signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
//  - out_valid stays high with stable out_result/out_tag until out_ready; the handshake edge returns to IDLE.
//    A new accept is possible the cycle after (no bypass from DONE to CALC).
//  - flush (any state) forces IDLE and out_valid=0 at the next edge and discards the result.
//    flush beats in_valid in the same cycle (no accept). flush in DONE with out_ready=1 also discards the result.
//  - rst_n low mid-operation aborts as for flush and clears all outputs.
//  - in_ready is combinational: (state==IDLE) & rst_n. It does not depend on in_valid.
// TESTING
//  1 MUL 64b: 7 * -3, word_op=0 -> out_result=0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 66 cycles after accept.
//  2 MULH/MULHU: 0xFFFF_FFFF_FFFF_FFFF*2 -> MULH=0xFFFF_FFFF_FFFF_FFFF, MULHU=0x1.
//    MULW 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE after 34 cycles.
//  3 DIV/REM: -7/2 -> DIV=-3, REM=-1. DIVU 100/7 -> 14, REMU -> 2. DIVW 0x1_0000_000A / 5 -> 2.
//  4 Special cases: DIV 5/0 -> all ones, REM 5/0 -> 5, DIV 0x8000_0000_0000_0000/-1 -> same, REM -> 0.
//    Each has out_valid 1 cycle after accept.
//  5 Handshake: out_ready low for 5 cycles -> result/tag stable, in_ready=0.
//    out_ready pulse -> in_ready=1 next cycle; back-to-back ops keep their tags in order.
//  6 flush in CALC cycle 10 with in_valid=1 -> no accept, IDLE next cycle, no out_valid.
//    rst_n=0 mid-DIV -> all outputs 0 after the edge.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Word ops work on bits [31:0] and return a sign-extended 32-bit result.
module mul_div_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic             word_op,
    input  logic [XLEN-1:0]  operand1,
    input  logic [XLEN-1:0]  operand2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       fsm_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid holds result/tag stable until out_ready, and flush overrides both sides.
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W  = XLEN'(signed'(32'h8000_0000));
    localparam logic [CW-1:0]   LAST_X = CW'(XLEN-1);
    localparam logic [CW-1:0]   LAST_W = CW'(31);

    state_t state, state_next;

    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opa;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] acc;
    logic              op_mul, op_high, op_rem, op_w, neg_prod, neg_rem;

    logic            accept, w_in, sgn1, sgn2, neg1, neg2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] sext1, sext2, x1, x2, mag1, mag2, special_res;

    logic            div_msb, ge, last;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_sub, rem_next, quot_s, rem_s, raw, fix_res;
    logic [2*XLEN-1:0] prod_s;

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;
    assign fsm_state = state;

    // Operand conditioning at accept: word truncation/extension, then magnitudes.
    assign w_in  = (XLEN == 64) && word_op;
    assign sgn1  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sgn2  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sext1 = XLEN'(signed'(operand1[31:0]));
    assign sext2 = XLEN'(signed'(operand2[31:0]));
    assign x1    = !w_in ? operand1 : (sgn1 ? sext1 : XLEN'(operand1[31:0]));
    assign x2    = !w_in ? operand2 : (sgn2 ? sext2 : XLEN'(operand2[31:0]));
    assign neg1  = sgn1 && x1[XLEN-1];
    assign neg2  = sgn2 && x2[XLEN-1];
    assign mag1  = neg1 ? -x1 : x1;
    assign mag2  = neg2 ? -x2 : x2;

    assign div_zero = funct3[2] && (x2 == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (x1 == (w_in ? MIN_W : MIN_X)) && (x2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '1;
        if (div_zero)
            special_res = funct3[1] ? (w_in ? sext1 : operand1) : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : x1;
    end

    // Restoring divide step: the next dividend bit comes from the top of the active width.
    assign div_msb   = op_w ? opa[31] : opa[XLEN-1];
    assign rem_shift = {acc[XLEN-1:0], div_msb};
    assign ge        = rem_shift >= {1'b0, mcand[XLEN-1:0]};
    assign rem_sub   = rem_shift[XLEN-1:0] - mcand[XLEN-1:0];
    assign rem_next  = ge ? rem_sub : rem_shift[XLEN-1:0];
    assign last      = (cnt == (op_w ? LAST_W : LAST_X));

    assign prod_s = neg_prod ? -acc : acc;
    assign quot_s = neg_prod ? -opa : opa;
    assign rem_s  = neg_rem ? -acc[XLEN-1:0] : acc[XLEN-1:0];

    always_comb begin
        raw = op_rem ? rem_s : quot_s;
        if (op_mul)
            raw = op_high ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        fix_res = op_w ? XLEN'(signed'(raw[31:0])) : raw;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (last) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            mcand      <= '0;
            acc        <= '0;
            op_mul     <= 1'b0;
            op_high    <= 1'b0;
            op_rem     <= 1'b0;
            op_w       <= 1'b0;
            neg_prod   <= 1'b0;
            neg_rem    <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_mul   <= !funct3[2];
                op_high  <= !w_in && (funct3[1:0] != 2'b00);
                op_rem   <= funct3[1];
                op_w     <= w_in;
                neg_prod <= neg1 ^ neg2;
                neg_rem  <= neg1;
                opa      <= mag1;
                mcand    <= {{XLEN{1'b0}}, mag2};
                acc      <= '0;
                cnt      <= '0;
                out_tag  <= tag_in;
                if (special) out_result <= special_res;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                if (op_mul) begin
                    if (opa[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    opa   <= opa >> 1;
                end else begin
                    acc <= {{XLEN{1'b0}}, rem_next};
                    opa <= {opa[XLEN-2:0], ge};
                end
            end else if (state == FIX && !flush) begin
                out_result <= fix_res;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, handshake/flush/reset scenarios and
// randomized ops against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, word_op, flush, out_valid, out_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  operand1, operand2, out_result;
    logic [TAG_W-1:0] tag_in, out_tag;
    logic [1:0]       fsm_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .word_op(word_op), .operand1(operand1), .operand2(operand2),
        .tag_in(tag_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .fsm_state(fsm_state)
    );

    // Reference model: plain arithmetic on the architectural definitions.
    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, p;
        logic [127:0]        ua, ub, up;
        logic signed [31:0]  a32, b32;
        logic signed [63:0]  s64a, s64b;
        logic [31:0]         r32;
        logic [63:0]         r;
        a32 = a[31:0]; b32 = b[31:0]; s64a = a; s64b = b;
        r32 = '0; r = '0;
        if (w) begin
            case (f)
                3'b100: begin
                    if (b32 == 0) r32 = 32'hFFFF_FFFF;
                    else if (a32 == 32'sh8000_0000 && b32 == -1) r32 = a32;
                    else r32 = a32 / b32;
                end
                3'b101: begin
                    if (b[31:0] == 0) r32 = 32'hFFFF_FFFF;
                    else r32 = a[31:0] / b[31:0];
                end
                3'b110: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'sh8000_0000 && b32 == -1) r32 = 0;
                    else r32 = a32 % b32;
                end
                3'b111: begin
                    if (b[31:0] == 0) r32 = a[31:0];
                    else r32 = a[31:0] % b[31:0];
                end
                default: r32 = a[31:0] * b[31:0];
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (f)
                3'b000: r = a * b;
                3'b001: begin sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b}; p = sa * sb; r = p[127:64]; end
                3'b010: begin sa = {{64{a[63]}}, a}; sb = {64'b0, b}; p = sa * sb; r = p[127:64]; end
                3'b011: begin ua = {64'b0, a}; ub = {64'b0, b}; up = ua * ub; r = up[127:64]; end
                3'b100: begin
                    if (b == 0) r = ONES;
                    else if (a == MIN64 && b == ONES) r = a;
                    else r = s64a / s64b;
                end
                3'b101: begin
                    if (b == 0) r = ONES;
                    else r = a / b;
                end
                3'b110: begin
                    if (b == 0) r = a;
                    else if (a == MIN64 && b == ONES) r = 0;
                    else r = s64a % s64b;
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (f[2]) begin
            if (w ? (b[31:0] == 0) : (b == 0)) return 1;
            if (!f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == MIN64 && b == ONES))) return 1;
        end
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return ONES;
            2: return MIN64;
            3: return 64'($urandom_range(0, 20));
            4: return {32'($urandom), 32'h8000_0000};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Driver: issue one op, wait (bounded) for the result, then consume it.
    task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         output logic [63:0] res, output logic [4:0] tg, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        funct3 = f; word_op = w; operand1 = a; operand2 = b; tag_in = tag; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk); lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
        res = out_result; tg = out_tag;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; word_op = 1'b0;
        funct3 = '0; operand1 = '0; operand2 = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 64'd0) begin bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_mul();
        vec_t v[6];
        logic [63:0] res; logic [4:0] tg; int lat;
        v[0] = '{name:"mul_7x-3", f:3'b000, w:1'b0, a:64'd7, b:64'hFFFF_FFFF_FFFF_FFFD, exp:64'hFFFF_FFFF_FFFF_FFEB, lat:66};
        v[1] = '{name:"mulh", f:3'b001, w:1'b0, a:ONES, b:64'd2, exp:ONES, lat:66};
        v[2] = '{name:"mulhu", f:3'b011, w:1'b0, a:ONES, b:64'd2, exp:64'd1, lat:66};
        v[3] = '{name:"mulhsu", f:3'b010, w:1'b0, a:ONES, b:64'd2, exp:ONES, lat:66};
        v[4] = '{name:"mulw", f:3'b000, w:1'b1, a:64'h7FFF_FFFF, b:64'd2, exp:64'hFFFF_FFFF_FFFF_FFFE, lat:34};
        v[5] = '{name:"mulw_f1", f:3'b001, w:1'b1, a:64'hFFFF_FFFF_0000_0003, b:64'd5, exp:64'd15, lat:34};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].f, v[i].w, v[i].a, v[i].b, 5'(i + 1), res, tg, lat);
            total++; if (res !== v[i].exp) begin bad++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
            total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
            total++; if (tg !== 5'(i + 1)) begin bad++; $display("FAIL %s tag: got %0d want %0d", v[i].name, tg, i + 1); end
        end
    endtask

    task automatic test_div();
        vec_t v[8];
        logic [63:0] res; logic [4:0] tg; int lat;
        v[0] = '{name:"div_-7/2", f:3'b100, w:1'b0, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, exp:64'hFFFF_FFFF_FFFF_FFFD, lat:66};
        v[1] = '{name:"rem_-7/2", f:3'b110, w:1'b0, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, exp:ONES, lat:66};
        v[2] = '{name:"divu_100/7", f:3'b101, w:1'b0, a:64'd100, b:64'd7, exp:64'd14, lat:66};
        v[3] = '{name:"remu_100/7", f:3'b111, w:1'b0, a:64'd100, b:64'd7, exp:64'd2, lat:66};
        v[4] = '{name:"divw", f:3'b100, w:1'b1, a:64'h1_0000_000A, b:64'd5, exp:64'd2, lat:34};
        v[5] = '{name:"remw", f:3'b110, w:1'b1, a:64'h1234_5678_FFFF_FFF9, b:64'd2, exp:ONES, lat:34};
        v[6] = '{name:"divuw", f:3'b101, w:1'b1, a:ONES - 64'd1, b:64'hABCD_0000_0000_0002, exp:64'h7FFF_FFFF, lat:34};
        v[7] = '{name:"divu_min/-1", f:3'b101, w:1'b0, a:MIN64, b:ONES, exp:64'd0, lat:66};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].f, v[i].w, v[i].a, v[i].b, 5'(i + 10), res, tg, lat);
            total++; if (res !== v[i].exp) begin bad++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
            total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
            total++; if (tg !== 5'(i + 10)) begin bad++; $display("FAIL %s tag: got %0d want %0d", v[i].name, tg, i + 10); end
        end
    endtask

    task automatic test_special();
        vec_t v[7];
        logic [63:0] res; logic [4:0] tg; int lat;
        v[0] = '{name:"div_by0", f:3'b100, w:1'b0, a:64'd5, b:64'd0, exp:ONES, lat:1};
        v[1] = '{name:"rem_by0", f:3'b110, w:1'b0, a:64'd5, b:64'd0, exp:64'd5, lat:1};
        v[2] = '{name:"div_ovf", f:3'b100, w:1'b0, a:MIN64, b:ONES, exp:MIN64, lat:1};
        v[3] = '{name:"rem_ovf", f:3'b110, w:1'b0, a:MIN64, b:ONES, exp:64'd0, lat:1};
        v[4] = '{name:"divuw_by0", f:3'b101, w:1'b1, a:64'h1_0000_0000, b:64'hF_0000_0000, exp:ONES, lat:1};
        v[5] = '{name:"remuw_by0", f:3'b111, w:1'b1, a:64'h8000_0000, b:64'h7_0000_0000, exp:64'hFFFF_FFFF_8000_0000, lat:1};
        v[6] = '{name:"divw_ovf", f:3'b100, w:1'b1, a:64'h8000_0000, b:64'hFFFF_FFFF, exp:64'hFFFF_FFFF_8000_0000, lat:1};
        for (int i = 0; i < 7; i++) begin
            do_op(v[i].f, v[i].w, v[i].a, v[i].b, 5'(i + 20), res, tg, lat);
            total++; if (res !== v[i].exp) begin bad++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
            total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
        end
    endtask

    task automatic test_handshake();
        logic [63:0] exp, res; logic [4:0] tg; int lat;
        logic [4:0] tag_q[$];
        logic [4:0] etag;
        int n = 0;
        exp = model(3'b101, 1'b0, 64'd1000, 64'd7);
        @(negedge clk);
        funct3 = 3'b101; word_op = 1'b0; operand1 = 64'd1000; operand2 = 64'd7; tag_in = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (out_result !== exp) begin bad++; $display("FAIL hold_result[%0d]: got %h want %h", i, out_result, exp); end
            total++; if (out_tag !== 5'd17) begin bad++; $display("FAIL hold_tag[%0d]: got %0d want 17", i, out_tag); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_pulse_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_pulse_out_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model(3'b100, 1'b1, 64'(100 + i * 37), 64'd3));
            tag_q.push_back(5'(3 + i));
        end
        for (int i = 0; i < 4; i++) begin
            do_op(3'b100, 1'b1, 64'(100 + i * 37), 64'd3, 5'(3 + i), res, tg, lat);
            exp = exp_q.pop_front();
            etag = tag_q.pop_front();
            total++; if (res !== exp) begin bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res, exp); end
            total++; if (tg !== etag) begin bad++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, tg, etag); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, exp, res; logic [4:0] tg, tag; logic [2:0] f; logic w; int lat, elat;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1));
            a = pick(); b = pick(); tag = 5'($urandom);
            exp_q.push_back(model(f, w, a, b));
            elat = exp_lat(f, w, a, b);
            do_op(f, w, a, b, tag, res, tg, lat);
            exp = exp_q.pop_front();
            total++; if (res !== exp) begin bad++; $display("FAIL rand[%0d] f=%b w=%b a=%h b=%h: got %h want %h", i, f, w, a, b, res, exp); end
            total++; if (lat !== elat) begin bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, elat); end
            total++; if (tg !== tag) begin bad++; $display("FAIL rand_tag[%0d]: got %0d want %0d", i, tg, tag); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] res; logic [4:0] tg; int lat, seen;
        @(negedge clk);
        funct3 = 3'b101; word_op = 1'b0; operand1 = 64'd1000; operand2 = 64'd3; tag_in = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b100; operand1 = 64'd5; operand2 = 64'd0; tag_in = 5'd9;
        @(posedge clk); #1 begin flush = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_calc_idle: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_calc_valid: got %b want 0", out_valid); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_calc_no_result: got %0d valid cycles want 0", seen); end
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 begin flush = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_beats_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_beats_valid_idle: got %b want 1", in_ready); end
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL special_next_cycle: got %b want 1", out_valid); end
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 begin flush = 1'b0; out_ready = 1'b0; end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_done_idle: got %b want 1", in_ready); end
        do_op(3'b101, 1'b0, 64'd1000, 64'd3, 5'd11, res, tg, lat);
        total++; if (res !== 64'd333) begin bad++; $display("FAIL after_flush_result: got %h want %h", res, 64'd333); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; logic [4:0] tg; int lat;
        @(negedge clk);
        funct3 = 3'b100; word_op = 1'b0; operand1 = 64'hFFFF_FFFF_FFFF_FC18; operand2 = 64'd7; tag_in = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 64'd0) begin bad++; $display("FAIL rst_mid_result: got %h want 0", out_result); end
        total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL rst_mid_tag: got %0d want 0", out_tag); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'd22, res, tg, lat);
        total++; if (res !== model(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7)) begin
            bad++; $display("FAIL after_rst_result: got %h want %h", res, model(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_handshake();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
